// File: rtl/d_mem_lsu.sv
// Load/store initiator for a word-wide data memory: byte/half/word loads with extension,
// sub-word stores via read-modify-write, alignment/range errors. req_ready only in IDLE.
module d_mem_lsu #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        signed_q, signed_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic        sub_store;
  logic [31:0] lane_data;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign accept    = req_valid && (state_q == IDLE);
  assign sub_store = we_q && (size_q != SZ_WORD);

  always_comb begin
    req_err = (req_size == SZ_BAD)
           || ((req_size == SZ_HALF) && req_addr[0])
           || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
           || (req_addr[31:2] >= 30'(DEPTH_WORDS));
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    lane_data = mem_rd >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: ext_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      SZ_HALF: ext_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: ext_data = mem_rd;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = sub_store ? MERGE : RESP;
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_we     = 1'b0;
    mem_wd     = 32'h0;
    case (state_q)
      ACCESS: begin
        if (we_q && (size_q == SZ_WORD)) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      MERGE: begin
        mem_we = 1'b1;
        mem_wd = merged;
      end
      default: ;
    endcase
  end

  // Response registers only change on the transition into RESP so they hold between responses.
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          size_d   = req_size;
          we_d     = req_we;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          if (req_err) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = ext_data;
          err_d   = 1'b0;
        end else if (size_q == SZ_WORD) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end else begin
          merge_d = mem_rd;
        end
      end
      MERGE: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_d_mem_lsu.sv
// Bench for d_mem_lsu: directed vector table, back-to-back and reset-in-RMW sequences,
// then random requests against a byte-lane arithmetic model with a shadow memory.
module tb_d_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        tb_wr_en;
  logic [5:0]  tb_wr_idx;
  logic [31:0] tb_wr_dat;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  d_mem_lsu #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && (mem_addr[31:8] == 24'h0)) mem[mem_addr[7:2]] <= mem_wd;
    else if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_dat;
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Shadow memory model: lanes computed with plain shifts/masks on a byte address.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int wcyc);
    int unsigned idx, off, nb;
    logic [31:0] mask, word, val;
    idx  = addr / 4;
    off  = addr % 4;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er   = (size == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= 64);
    rd   = 32'h0;
    wcyc = 0;
    lat  = 1;
    if (er) return;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    word = ref_mem[idx];
    if (!we) begin
      val = (word >> (8 * off)) & mask;
      if (sgn && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
      rd  = val;
      lat = 2;
    end else begin
      ref_mem[idx] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      lat  = (nb == 4) ? 2 : 3;
      wcyc = lat - 1;
    end
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    tb_wr_en  = 1'b1;
    tb_wr_idx = 6'(idx);
    tb_wr_dat = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 tb_wr_en = 1'b0;
  endtask

  // Starts right after an accepting edge; cycle 1 is the first cycle after acceptance.
  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er,
                           output int wcyc, output int wcnt);
    lat = 0; rd = 32'h0; er = 1'b0; wcyc = 0; wcnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wcnt++;
        wcyc = c;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic pre_rdy, output logic pre_resp,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int wcyc, output int wcnt);
    @(negedge clk);
    pre_rdy    = req_ready;
    pre_resp   = resp_valid;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat, rd, er, wcyc, wcnt);
  endtask

  vec_t        vt[17];
  logic        pre_rdy, pre_resp, er, m_er;
  logic [31:0] rd, m_rd, old_w;
  int          lat, wcyc, wcnt, m_lat, m_wcyc;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    tb_wr_en = 1'b0; tb_wr_idx = 6'h0; tb_wr_dat = 32'h0;

    vt[0]  = '{"ld_b_s_0d", 1'b0, 2'd0, 1'b1, 32'h0D,  32'h0,        32'hFFFF_FFAA, 1'b0, 2};
    vt[1]  = '{"ld_h_u_0e", 1'b0, 2'd1, 1'b0, 32'h0E,  32'h0,        32'h0000_8899, 1'b0, 2};
    vt[2]  = '{"ld_w_0c",   1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        32'h8899_AABB, 1'b0, 2};
    vt[3]  = '{"ld_b_u_0c", 1'b0, 2'd0, 1'b0, 32'h0C,  32'h0,        32'h0000_00BB, 1'b0, 2};
    vt[4]  = '{"ld_h_s_0c", 1'b0, 2'd1, 1'b1, 32'h0C,  32'h0,        32'hFFFF_AABB, 1'b0, 2};
    vt[5]  = '{"ld_b_s_0f", 1'b0, 2'd0, 1'b1, 32'h0F,  32'h0,        32'hFFFF_FF88, 1'b0, 2};
    vt[6]  = '{"st_b_09",   1'b1, 2'd0, 1'b0, 32'h09,  32'hABCD_EFEE, 32'h0,        1'b0, 3};
    vt[7]  = '{"ld_w_08",   1'b0, 2'd2, 1'b0, 32'h08,  32'h0,        32'h1122_EE44, 1'b0, 2};
    vt[8]  = '{"st_h_03",   1'b1, 2'd1, 1'b0, 32'h03,  32'h0000_FFFF, 32'h0,        1'b1, 1};
    vt[9]  = '{"st_w_06",   1'b1, 2'd2, 1'b0, 32'h06,  32'h1234_5678, 32'h0,        1'b1, 1};
    vt[10] = '{"st_w_100",  1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 32'h0,        1'b1, 1};
    vt[11] = '{"ld_sz3",    1'b0, 2'd3, 1'b0, 32'h00,  32'h0,        32'h0,        1'b1, 1};
    vt[12] = '{"ld_w_fc",   1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'h3F3F_3F99, 1'b0, 2};
    vt[13] = '{"st_w_10",   1'b1, 2'd2, 1'b0, 32'h10,  32'hCAFE_F00D, 32'h0,        1'b0, 2};
    vt[14] = '{"st_h_12",   1'b1, 2'd1, 1'b0, 32'h12,  32'h5566_1234, 32'h0,        1'b0, 3};
    vt[15] = '{"ld_w_10",   1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h1234_F00D, 1'b0, 2};
    vt[16] = '{"ld_h_s_10", 1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'hFFFF_F00D, 1'b0, 2};

    #12;
    chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata,          32'h0);
    chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
    chk("rst_mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst_mem_addr",   mem_addr,            32'h0);
    chk("rst_mem_wd",     mem_wd,              32'h0);

    for (int i = 0; i < 64; i++) poke(i, (32'(i) * 32'h0101_0101) + 32'h5A);
    poke(2, 32'h1122_3344);
    poke(3, 32'h8899_AABB);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      model(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, m_rd, m_er, m_lat, m_wcyc);
      do_req(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata,
             pre_rdy, pre_resp, lat, rd, er, wcyc, wcnt);
      chk({vt[i].name, "_ready"}, {31'h0, pre_rdy},  32'h1);
      chk({vt[i].name, "_idle"},  {31'h0, pre_resp}, 32'h0);
      chk({vt[i].name, "_lat"},   32'(lat),          32'(vt[i].exp_lat));
      chk({vt[i].name, "_rdata"}, rd,                vt[i].exp_rdata);
      chk({vt[i].name, "_err"},   {31'h0, er},       {31'h0, vt[i].exp_err});
      chk({vt[i].name, "_wcnt"},  32'(wcnt),         (vt[i].we && !vt[i].exp_err) ? 32'h1 : 32'h0);
      chk({vt[i].name, "_wcyc"},  32'(wcyc),         (vt[i].we && !vt[i].exp_err) ? 32'(vt[i].exp_lat - 1) : 32'h0);
    end
    chk("tbl_mem2", mem[2], 32'h1122_EE44);
    chk("tbl_mem4", mem[4], 32'h1234_F00D);
    chk("tbl_mem1", mem[1], ref_mem[1]);

    // Back-to-back with req_valid held: sub-word store, then a load.
    model(1'b1, 2'd0, 1'b0, 32'h1A, 32'h0000_0077, m_rd, m_er, m_lat, m_wcyc);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h1A; req_wdata = 32'h0000_0077;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), {31'h0, req_ready}, 32'h0);
      req_we = 1'b0; req_size = 2'd3; req_addr = 32'hFFFF_FFFF;
    end
    chk("b2b_resp1", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
    chk("b2b_ready_c4", {31'h0, req_ready}, 32'h1);
    chk("b2b_resp1_drop", {31'h0, resp_valid}, 32'h0);
    model(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, m_rd, m_er, m_lat, m_wcyc);
    req_size = 2'd2; req_addr = 32'h18;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat, rd, er, wcyc, wcnt);
    chk("b2b_lat2", 32'(lat), 32'(m_lat));
    chk("b2b_rdata2", rd, m_rd);

    // Reset asserted while the RMW is in MERGE.
    @(negedge clk);
    old_w = mem[4];
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst6_we_access", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rst6_we_merge", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst6_we_drop", {31'h0, mem_we}, 32'h0);
    chk("rst6_ready_now", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    chk("rst6_mem4", mem[4], old_w);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst6_ready_after", {31'h0, req_ready}, 32'h1);
    chk("rst6_resp_valid", {31'h0, resp_valid}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        r_we, r_sgn;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h10F));
      r_wd   = $urandom;
      model(r_we, r_size, r_sgn, r_addr, r_wd, m_rd, m_er, m_lat, m_wcyc);
      do_req(r_we, r_size, r_sgn, r_addr, r_wd, pre_rdy, pre_resp, lat, rd, er, wcyc, wcnt);
      chk($sformatf("rnd%0d_lat", i),   32'(lat),    32'(m_lat));
      chk($sformatf("rnd%0d_rdata", i), rd,          m_rd);
      chk($sformatf("rnd%0d_err", i),   {31'h0, er}, {31'h0, m_er});
      chk($sformatf("rnd%0d_wcyc", i),  32'(wcyc),   32'(m_wcyc));
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
